fila_escrita_registradores: RTL

// - Write-back queue directly upstream of the 32x32 register file; its outputs drive the write address, write data and write enable.
// - Merges two write-back sources, ALU results and memory loads, into the register file's single write port.
// - Buffers up to PROFUNDIDADE pending writes and drains one per cycle in acceptance order.

---
 rtl/fila_escrita_registradores_if.sv | 42 ++++
 rtl/fila_escrita_registradores.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fila_escrita_registradores_if.sv
// Write-back bundle between the ALU/load sources, the queue and the register file write port.
// Includes the forwarding lookup port used when FILA_ESCRITA_ENCAMINHAMENTO_EN is defined.
interface fila_escrita_registradores_if #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARGURA      = 32
);
  logic                                ula_valido;
  logic                                ula_pronto;
  logic [4:0]                          ula_endereco;
  logic [LARGURA-1:0]                  ula_dados;
  logic                                mem_valido;
  logic                                mem_pronto;
  logic [4:0]                          mem_endereco;
  logic [LARGURA-1:0]                  mem_dados;
  logic [4:0]                          endereco_E;
  logic [LARGURA-1:0]                  dados;
  logic                                escreve_R;
  logic                                vazio;
  logic                                cheio;
  logic [$clog2(PROFUNDIDADE+1)-1:0]   ocupacao;
  logic [4:0]                          consulta_endereco;
  logic                                consulta_acerto;
  logic [LARGURA-1:0]                  consulta_dados;

  modport slave (
    input  ula_valido, ula_endereco, ula_dados,
    input  mem_valido, mem_endereco, mem_dados,
    input  consulta_endereco,
    output ula_pronto, mem_pronto,
    output endereco_E, dados, escreve_R, vazio, cheio, ocupacao,
    output consulta_acerto, consulta_dados
  );

  modport master (
    output ula_valido, ula_endereco, ula_dados,
    output mem_valido, mem_endereco, mem_dados,
    output consulta_endereco,
    input  ula_pronto, mem_pronto,
    input  endereco_E, dados, escreve_R, vazio, cheio, ocupacao,
    input  consulta_acerto, consulta_dados
  );
endinterface

// File: rtl/fila_escrita_registradores.sv
// Write-back queue merging ALU and load results into the register file's single write port.
// Optional forwarding lookup over queued entries: define FILA_ESCRITA_ENCAMINHAMENTO_EN.
module fila_escrita_registradores #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARGURA      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  fila_escrita_registradores_if.slave   bus
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int OW = $clog2(PROFUNDIDADE + 1);
  localparam logic [OW-1:0] OCUP_CHEIA = OW'(PROFUNDIDADE);

  typedef enum logic {
    FAVORECE_ULA = 1'b0,
    FAVORECE_MEM = 1'b1
  } turno_e;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      ocup_q, ocup_d;
  turno_e             turno_q, turno_d;

  logic [4:0]         end_mem   [PROFUNDIDADE];
  logic [LARGURA-1:0] dados_mem [PROFUNDIDADE];

  logic               vazio, cheio;
  logic               ula_pronto, mem_pronto;
  logic               push, pop;
  logic [4:0]         ent_end;
  logic [LARGURA-1:0] ent_dados;

  always_comb begin
    vazio      = (ocup_q == '0);
    cheio      = (ocup_q == OCUP_CHEIA);
    // The source not granted last wins a tie; a lone requester always wins.
    ula_pronto = bus.ula_valido && !cheio &&
                 (!bus.mem_valido || (turno_q == FAVORECE_ULA));
    mem_pronto = bus.mem_valido && !cheio &&
                 (!bus.ula_valido || (turno_q == FAVORECE_MEM));
    ent_end    = ula_pronto ? bus.ula_endereco : bus.mem_endereco;
    ent_dados  = ula_pronto ? bus.ula_dados    : bus.mem_dados;
    // Register 0 writes complete the handshake but occupy no slot.
    push       = (ula_pronto || mem_pronto) && (ent_end != 5'd0);
    pop        = !vazio;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    ocup_d = ocup_q;
    if (push && !pop)      ocup_d = ocup_q + OW'(1);
    else if (!push && pop) ocup_d = ocup_q - OW'(1);

    turno_d = turno_q;
    if (ula_pronto)      turno_d = FAVORECE_MEM;
    else if (mem_pronto) turno_d = FAVORECE_ULA;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
      turno_q  <= FAVORECE_ULA;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      turno_q  <= turno_d;
    end
  end

  // NOTE: storage is not reset; stale slots are never visible because outputs are gated by occupancy.
  always_ff @(posedge clock) begin
    if (push) begin
      end_mem[wr_ptr_q]   <= ent_end;
      dados_mem[wr_ptr_q] <= ent_dados;
    end
  end

  assign bus.ula_pronto = ula_pronto;
  assign bus.mem_pronto = mem_pronto;
  assign bus.vazio      = vazio;
  assign bus.cheio      = cheio;
  assign bus.ocupacao   = ocup_q;
  assign bus.escreve_R  = !vazio;
  assign bus.endereco_E = vazio ? 5'd0 : end_mem[rd_ptr_q];
  assign bus.dados      = vazio ? '0   : dados_mem[rd_ptr_q];

`ifdef FILA_ESCRITA_ENCAMINHAMENTO_EN
  logic [PW-1:0]      busca_idx;
  logic               acerto;
  logic [LARGURA-1:0] acerto_dados;

  // Scan oldest to newest so the last match left standing is the newest pending value.
  always_comb begin
    acerto       = 1'b0;
    acerto_dados = '0;
    busca_idx    = rd_ptr_q;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      busca_idx = rd_ptr_q + PW'(i);
      if ((OW'(i) < ocup_q) && (bus.consulta_endereco != 5'd0) &&
          (end_mem[busca_idx] == bus.consulta_endereco)) begin
        acerto       = 1'b1;
        acerto_dados = dados_mem[busca_idx];
      end
    end
  end

  assign bus.consulta_acerto = acerto;
  assign bus.consulta_dados  = acerto_dados;
`else
  assign bus.consulta_acerto = 1'b0;
  assign bus.consulta_dados  = '0;
`endif

endmodule
